// File: rtl/step_motion_profiler.sv
// Purpose : trapezoidal step-rate generator owning the signed step position that feeds the
//           full-step waveform decoder; follows external STEP/DIR pins when ext_mode=1.
// Latency : all outputs registered; first internal step lands sstart cycles after busy rises.
// Backpressure: none; start/ext_step are sampled in IDLE only and ignored while busy.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start, abort                 move request (IDLE only) / stop move in progress
//   target_pos                   absolute signed target position
//   start_period, min_period     slowest / fastest step period in clk cycles
//   accel_dec                    period change per step while ramping
//   ext_mode, ext_step, ext_dir  external STEP/DIR follow mode (ext_dir=1 -> -1)
//   cur_step_pos                 current position
//   step_pulse, dir, busy, done  step strobe, direction (1=negative), move active, move end strobe
module step_motion_profiler #(
    parameter int POS_W = 32,
    parameter int PER_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [POS_W-1:0] target_pos,
    input  logic [PER_W-1:0] start_period,
    input  logic [PER_W-1:0] min_period,
    input  logic [PER_W-1:0] accel_dec,
    input  logic             ext_mode,
    input  logic             ext_step,
    input  logic             ext_dir,
    output logic [POS_W-1:0] cur_step_pos,
    output logic             step_pulse,
    output logic             dir,
    output logic             busy,
    output logic             done
);

    // One extra bit of headroom so period +/- accel never wraps.
    localparam int PW = PER_W + 1;

    typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, DECEL} state_t;

    state_t           state_q;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] rem_q;
    logic [POS_W-1:0] ramp_q;
    logic [PW-1:0]    period_q;
    logic [PW-1:0]    timer_q;
    logic [PW-1:0]    smin_q;
    logic [PW-1:0]    sstart_q;
    logic [PW-1:0]    accel_q;
    logic             step_q;
    logic             dir_q;
    logic             busy_q;
    logic             done_q;

    // Move setup derived from the live inputs; only used on the cycle a start is accepted.
    logic [PW-1:0]    smin_d;
    logic [PW-1:0]    sstart_d;
    logic [POS_W-1:0] delta_d;
    logic [POS_W-1:0] abs_delta_d;

    always_comb begin
        smin_d      = (min_period == '0) ? PW'(1) : {1'b0, min_period};
        sstart_d    = ({1'b0, start_period} > smin_d) ? {1'b0, start_period} : smin_d;
        delta_d     = target_pos - pos_q;
        abs_delta_d = delta_d[POS_W-1] ? (~delta_d + POS_W'(1)) : delta_d;
    end

    // Profile update applied at each step: remaining is decremented first, then the
    // ramp decision is made against the decremented value.
    logic [POS_W-1:0] rem_d;
    logic [POS_W-1:0] ramp_d;
    logic [PW-1:0]    period_d;
    logic [PW-1:0]    period_up;
    logic [PW-1:0]    sum_up;
    state_t           state_d;

    always_comb begin
        rem_d     = rem_q - POS_W'(1);
        sum_up    = period_q + accel_q;
        period_up = (sum_up > sstart_q) ? sstart_q : sum_up;
        state_d   = state_q;
        period_d  = period_q;
        ramp_d    = ramp_q;
        if (rem_d == '0) begin
            state_d = IDLE;
        end else if ((state_q != DECEL) && (rem_d <= ramp_q)) begin
            // Braking distance reached: mirror the ramp-up back down.
            state_d  = DECEL;
            period_d = period_up;
        end else if (state_q == ACCEL) begin
            // period - accel <= smin, rearranged so the subtraction cannot underflow.
            if (period_q <= smin_q + accel_q) begin
                period_d = smin_q;
                state_d  = CRUISE;
            end else begin
                period_d = period_q - accel_q;
                ramp_d   = ramp_q + POS_W'(1);
            end
        end else if (state_q == DECEL) begin
            period_d = period_up;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pos_q    <= '0;
            rem_q    <= '0;
            ramp_q   <= '0;
            period_q <= '0;
            timer_q  <= '0;
            smin_q   <= '0;
            sstart_q <= '0;
            accel_q  <= '0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            step_q <= 1'b0;
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (ext_mode) begin
                    if (ext_step) begin
                        pos_q <= ext_dir ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
                    end
                end else if (start) begin
                    if (delta_d == '0) begin
                        done_q <= 1'b1;
                    end else begin
                        dir_q    <= delta_d[POS_W-1];
                        rem_q    <= abs_delta_d;
                        ramp_q   <= '0;
                        period_q <= sstart_d;
                        timer_q  <= sstart_d;
                        smin_q   <= smin_d;
                        sstart_q <= sstart_d;
                        accel_q  <= {1'b0, accel_dec};
                        busy_q   <= 1'b1;
                        state_q  <= ACCEL;
                    end
                end
            end else begin
                // Period is always >= 1, so timer reaching 1 marks expiry on this edge.
                if (timer_q == PW'(1)) begin
                    step_q   <= 1'b1;
                    pos_q    <= dir_q ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
                    rem_q    <= rem_d;
                    ramp_q   <= ramp_d;
                    period_q <= period_d;
                    timer_q  <= period_d;
                    state_q  <= state_d;
                    if (rem_d == '0) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end else begin
                    timer_q <= timer_q - PW'(1);
                end
                // Abort wins over everything except a step already due on this edge.
                if (abort) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign cur_step_pos = pos_q;
    assign step_pulse   = step_q;
    assign dir          = dir_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
